// File: rtl/vga_timing_pkg.sv
// Nominal 640x480@60 timing, monitor FSM encoding and CRC constants shared
// by the VGA receive-side monitor.
package vga_timing_pkg;
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // First visible sample trails the first high hsync sample by back porch + 1.
  localparam int VGA_H_START     = VGA_H_BACK + 1;
  localparam int VGA_V_START     = VGA_V_BACK;
  localparam int VGA_LOCK_FRAMES = 2;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_LOCKED = 2'd2
  } mon_state_t;
endpackage

// File: rtl/crc16_ccitt_12.sv
// Combinational CRC-16-CCITT step over one 12-bit word, MSB first,
// no reflection.
module crc16_ccitt_12
  import vga_timing_pkg::*;
(
  input  logic [15:0] i_crc,
  input  logic [11:0] i_data,
  output logic [15:0] o_crc
);
  logic [15:0] w_c;

  always_comb begin
    w_c = i_crc;
    for (int i = 11; i >= 0; i--) begin
      if (w_c[15] ^ i_data[i]) w_c = {w_c[14:0], 1'b0} ^ CRC_POLY;
      else                     w_c = {w_c[14:0], 1'b0};
    end
  end

  assign o_crc = w_c;
endmodule

// File: rtl/vga_sync_monitor.sv
// VGA receive-side monitor: recovers the pixel grid from sampled syncs,
// checks line/frame periods, tracks lock, blanking and per-frame CRC.
module vga_sync_monitor
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int H_VISIBLE   = VGA_H_VISIBLE,
  parameter int V_VISIBLE   = VGA_V_VISIBLE,
  parameter int H_START     = VGA_H_START,
  parameter int V_START     = VGA_V_START,
  parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic [11:0] rgb,
  output logic        pixel_valid,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic [11:0] pixel_rgb,
  output logic        frame_done,
  output logic [15:0] frame_crc,
  output logic        locked,
  output logic        h_period_err,
  output logic        v_period_err,
  output logic        blank_err
);
  localparam logic [10:0] HC_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] HV_LO   = 11'(H_START - 1);
  localparam logic [10:0] HV_HI   = 11'(H_START - 1 + H_VISIBLE);
  localparam logic [9:0]  LC_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VV_LO   = 10'(V_START);
  localparam logic [9:0]  VV_HI   = 10'(V_START + V_VISIBLE);
  localparam logic [9:0]  X_LAST  = 10'(H_VISIBLE - 1);
  localparam logic [9:0]  Y_LAST  = 10'(V_VISIBLE - 1);
  localparam logic [7:0]  LOCK_M1 = 8'(LOCK_FRAMES - 1);

  logic        r_hs1, r_hs2, r_vs1, r_vs2;
  logic [11:0] r_rgb1;
  logic [10:0] r_hc;
  logic [9:0]  r_lc;
  logic        r_h_seen, r_v_seen;
  mon_state_t  r_state, w_state_nx;
  logic [7:0]  r_clean, w_clean_nx;
  logic        r_dirty, w_dirty_nx;
  logic [15:0] r_crc, w_crc_nx;
  logic        r_frame_ok;
  logic        r_p1_vld, r_p1_last, r_p2_last;
  logic [9:0]  r_p1_x, r_p1_y;
  logic [11:0] r_p1_rgb;

  logic       w_h_rise, w_v_rise, w_h_bad, w_v_bad, w_perr;
  logic       w_win, w_vis, w_first, w_last;
  logic [9:0] w_px, w_py;

  assign w_h_rise = r_hs1 & ~r_hs2;
  assign w_v_rise = r_vs1 & ~r_vs2;
  assign w_h_bad  = w_h_rise & r_h_seen & (r_hc != HC_LAST);
  assign w_v_bad  = w_v_rise & r_v_seen & (r_lc != LC_LAST);
  assign w_perr   = w_h_bad | w_v_bad;

  // Window is evaluated against the first-stage rgb sample.
  assign w_win   = (r_hc >= HV_LO) && (r_hc < HV_HI) && (r_lc >= VV_LO) && (r_lc < VV_HI);
  assign w_vis   = w_win && (r_state != ST_SEARCH);
  assign w_px    = 10'(r_hc - HV_LO);
  assign w_py    = r_lc - VV_LO;
  assign w_first = w_vis && (w_px == 10'd0) && (w_py == 10'd0);
  assign w_last  = w_vis && (w_px == X_LAST) && (w_py == Y_LAST);
  assign locked  = (r_state == ST_LOCKED);

  crc16_ccitt_12 u_crc (
    .i_crc  (w_first ? CRC_INIT : r_crc),
    .i_data (r_rgb1),
    .o_crc  (w_crc_nx)
  );

  always_comb begin
    w_state_nx = r_state;
    w_clean_nx = r_clean;
    // A period error taints the frame it lands in; a vsync rise opens a fresh one.
    w_dirty_nx = w_v_rise ? 1'b0 : (r_dirty | w_perr);
    unique case (r_state)
      ST_SEARCH: if (w_v_rise) begin
        w_state_nx = ST_ALIGN;
        w_clean_nx = '0;
      end
      ST_ALIGN: begin
        if (w_perr) w_clean_nx = '0;
        else if (w_v_rise && !r_dirty) begin
          if (r_clean == LOCK_M1) begin
            w_state_nx = ST_LOCKED;
            w_clean_nx = '0;
          end else begin
            w_clean_nx = r_clean + 8'd1;
          end
        end
      end
      ST_LOCKED: if (w_perr) begin
        w_state_nx = ST_ALIGN;
        w_clean_nx = '0;
      end
      default: w_state_nx = ST_SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hs1 <= 1'b1; r_hs2 <= 1'b1; r_vs1 <= 1'b1; r_vs2 <= 1'b1;
      r_rgb1 <= '0;
      r_hc <= '0; r_lc <= '0;
      r_h_seen <= 1'b0; r_v_seen <= 1'b0;
      r_state <= ST_SEARCH; r_clean <= '0; r_dirty <= 1'b0;
      r_crc <= CRC_INIT; r_frame_ok <= 1'b0;
      r_p1_vld <= 1'b0; r_p1_last <= 1'b0; r_p2_last <= 1'b0;
      r_p1_x <= '0; r_p1_y <= '0; r_p1_rgb <= '0;
      pixel_valid <= 1'b0; pixel_x <= '0; pixel_y <= '0; pixel_rgb <= '0;
      frame_done <= 1'b0; frame_crc <= '0;
      h_period_err <= 1'b0; v_period_err <= 1'b0; blank_err <= 1'b0;
    end else begin
      r_hs1 <= h_sync; r_hs2 <= r_hs1;
      r_vs1 <= v_sync; r_vs2 <= r_vs1;
      r_rgb1 <= rgb;

      if (w_h_rise)              r_hc <= '0;
      else if (r_hc != 11'h7FF)  r_hc <= r_hc + 11'd1;
      if (w_v_rise)      r_lc <= '0;
      else if (w_h_rise) r_lc <= r_lc + 10'd1;
      r_h_seen <= r_h_seen | w_h_rise;
      r_v_seen <= r_v_seen | w_v_rise;

      r_state <= w_state_nx;
      r_clean <= w_clean_nx;
      r_dirty <= w_dirty_nx;

      if (w_vis)       r_crc <= w_crc_nx;
      if (w_perr)      r_frame_ok <= 1'b0;
      else if (w_first) r_frame_ok <= 1'b1;

      r_p1_vld  <= w_vis;
      r_p1_x    <= w_vis ? w_px : 10'd0;
      r_p1_y    <= w_vis ? w_py : 10'd0;
      r_p1_rgb  <= w_vis ? r_rgb1 : 12'h000;
      r_p1_last <= w_last & (r_frame_ok | w_first) & ~w_perr;

      pixel_valid <= r_p1_vld;
      pixel_x     <= r_p1_x;
      pixel_y     <= r_p1_y;
      pixel_rgb   <= r_p1_rgb;
      r_p2_last   <= r_p1_last;

      frame_done <= r_p2_last;
      if (r_p2_last) frame_crc <= r_crc;

      h_period_err <= w_h_bad;
      v_period_err <= w_v_bad;
      if (locked && !w_win && (r_rgb1 != 12'h000)) blank_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor on a scaled-down raster (40x30 clocks/lines).
module tb_vga_sync_monitor;
  localparam int HT = 40, HV = 16, HS = 9;
  localparam int VT = 30, VV = 12, VS = 5;
  localparam int LF = 2;
  localparam int SHORT_L = 8, INJ_L = 8, INJ_C = 3;
  localparam logic [11:0] SOLID = 12'hF00;
  localparam int BUDGET = 3000;

  logic        clk = 1'b0, reset = 1'b1, h_sync = 1'b1, v_sync = 1'b1;
  logic [11:0] rgb = 12'h000;
  logic        pixel_valid, frame_done, locked, h_period_err, v_period_err, blank_err;
  logic [9:0]  pixel_x, pixel_y;
  logic [11:0] pixel_rgb;
  logic [15:0] frame_crc;

  vga_sync_monitor #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_VISIBLE(HV), .V_VISIBLE(VV),
    .H_START(HS), .V_START(VS), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .reset(reset), .h_sync(h_sync), .v_sync(v_sync), .rgb(rgb),
    .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_rgb(pixel_rgb), .frame_done(frame_done), .frame_crc(frame_crc),
    .locked(locked), .h_period_err(h_period_err), .v_period_err(v_period_err),
    .blank_err(blank_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, gc = 0, gl = VT - 2, cur_len = HT, cur_pat = 0, next_pat = 0;
  int drv_l = -1, drv_c = -1;
  bit gen_en = 0, short_req = 0, inj_req = 0;
  int pv_cnt = 0, pv_total = 0, fd_n = 0, fd_cyc = 0, fd_period = 0, fd_last_pv = 0;
  int herr_n = 0, verr_n = 0;

  function automatic logic [11:0] pix(int pat, int x, int y);
    if (pat == 1) return 12'(x ^ y);
    if (pat == 2 && x == 0 && y == 0) return 12'h123;
    if (pat == 2 && x == HV - 1 && y == VV - 1) return 12'h0AB;
    return SOLID;
  endfunction

  function automatic logic [15:0] model_crc(int pat);
    logic [15:0] c;
    logic [11:0] d;
    logic        fb;
    c = 16'hFFFF;
    for (int y = 0; y < VV; y++)
      for (int x = 0; x < HV; x++) begin
        d = pix(pat, x, y);
        for (int b = 11; b >= 0; b--) begin
          fb = c[15] ^ d[b];
          c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
      end
    return c;
  endfunction

  // Negedge: sample DUT outputs into counters, then drive the next raster column.
  always @(negedge clk) begin
    if (pixel_valid) begin pv_cnt++; pv_total++; end
    if (frame_done) begin
      fd_last_pv = pv_cnt; pv_cnt = 0;
      fd_period = cyc - fd_cyc; fd_cyc = cyc; fd_n++;
    end
    if (h_period_err) herr_n++;
    if (v_period_err) verr_n++;
    cyc++;
    if (gen_en) begin
      if (gc == 0) begin
        if (gl == 0) cur_pat = next_pat;
        cur_len = HT;
        if (short_req && gl == SHORT_L) begin cur_len = HT - 1; short_req = 0; end
      end
      h_sync = (gc < cur_len - 8);
      v_sync = (gl < VT - 2);
      if (gc >= HS && gc < HS + HV && gl >= VS && gl < VS + VV) rgb = pix(cur_pat, gc - HS, gl - VS);
      else rgb = 12'h000;
      if (inj_req && gl == INJ_L && gc == INJ_C) begin rgb = 12'h001; inj_req = 0; end
      drv_l = gl; drv_c = gc;
      gc++;
      if (gc == cur_len) begin gc = 0; gl = (gl == VT - 1) ? 0 : gl + 1; end
    end
  end

  // Returns at 1 time unit after the posedge that sampled column (l,c).
  task automatic wait_drive(input int l, input int c);
    bit hit = 0;
    for (int n = 0; n < BUDGET; n++) begin
      @(posedge clk); #1;
      if (drv_l == l && drv_c == c) begin hit = 1; break; end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL wait_drive(%0d,%0d): timed out", l, c); end
  endtask

  task automatic wait_fd(input int target);
    bit hit = 0;
    for (int n = 0; n < BUDGET; n++) begin
      @(posedge clk); #1;
      if (fd_n >= target) begin hit = 1; break; end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL wait_fd: got %0d frame_done want %0d", fd_n, target); end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (3) step();
    checks++;
    if ({pixel_valid, pixel_x, pixel_y, pixel_rgb, frame_done, frame_crc, locked,
         h_period_err, v_period_err, blank_err} !== 54'd0) begin
      errors++; $display("FAIL reset_outputs: got nonzero outputs, want all 0");
    end
    reset = 1'b0;
    repeat (3) step();
    checks++;
    if ({pixel_valid, frame_done, frame_crc, locked, h_period_err, v_period_err, blank_err} !== 22'd0) begin
      errors++; $display("FAIL idle_after_reset: got nonzero outputs, want all 0");
    end
    gen_en = 1;
  endtask

  task automatic test_lock;
    wait_drive(0, 0);
    wait_drive(0, 0);
    wait_drive(0, 0);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL lock_early: got %b want 0", locked); end
    step();
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL lock_rise: got %b want 1", locked); end
  endtask

  task automatic test_nominal;
    int fd0, h0, v0;
    fd0 = fd_n; h0 = herr_n; v0 = verr_n;
    wait_fd(fd0 + 2);
    checks++;
    if (fd_last_pv != HV * VV) begin errors++; $display("FAIL pixels_per_frame: got %0d want %0d", fd_last_pv, HV * VV); end
    checks++;
    if (fd_period != HT * VT) begin errors++; $display("FAIL frame_period: got %0d want %0d", fd_period, HT * VT); end
    checks++;
    if (herr_n != h0 || verr_n != v0) begin errors++; $display("FAIL nominal_period_errs: got h%0d v%0d want 0", herr_n - h0, verr_n - v0); end
    checks++;
    if (blank_err !== 1'b0 || locked !== 1'b1) begin errors++; $display("FAIL nominal_flags: got blank %b locked %b want 0 1", blank_err, locked); end
    checks++;
    if (frame_crc !== model_crc(0)) begin errors++; $display("FAIL crc_solid: got %h want %h", frame_crc, model_crc(0)); end
  endtask

  task automatic test_corners;
    next_pat = 2;
    wait_drive(0, 0);
    wait_drive(VS, HS);
    step();
    checks++;
    if (pixel_valid !== 1'b0) begin errors++; $display("FAIL first_pix_early: got pv %b want 0", pixel_valid); end
    step();
    checks++;
    if ({pixel_valid, pixel_x, pixel_y, pixel_rgb} !== {1'b1, 10'd0, 10'd0, 12'h123}) begin
      errors++; $display("FAIL first_pix: got pv%b x%0d y%0d rgb%h want 1 0 0 123", pixel_valid, pixel_x, pixel_y, pixel_rgb);
    end
    wait_drive(VS + VV - 1, HS + HV - 1);
    step(); step();
    checks++;
    if ({pixel_valid, pixel_x, pixel_y, pixel_rgb, frame_done} !==
        {1'b1, 10'(HV - 1), 10'(VV - 1), 12'h0AB, 1'b0}) begin
      errors++; $display("FAIL last_pix: got pv%b x%0d y%0d rgb%h fd%b want 1 %0d %0d 0ab 0",
                         pixel_valid, pixel_x, pixel_y, pixel_rgb, frame_done, HV - 1, VV - 1);
    end
    step();
    checks++;
    if ({frame_done, pixel_valid} !== 2'b10) begin errors++; $display("FAIL frame_done_pulse: got fd%b pv%b want 1 0", frame_done, pixel_valid); end
    checks++;
    if (frame_crc !== model_crc(2)) begin errors++; $display("FAIL crc_corners: got %h want %h", frame_crc, model_crc(2)); end
    step();
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL frame_done_width: got %b want 0", frame_done); end
  endtask

  task automatic test_short_line;
    int fd0, h0, v0;
    next_pat = 0;
    wait_drive(0, 0);
    wait_fd(fd_n + 1);
    checks++;
    if (frame_crc !== model_crc(0)) begin errors++; $display("FAIL crc_solid_again: got %h want %h", frame_crc, model_crc(0)); end
    fd0 = fd_n; h0 = herr_n; v0 = verr_n;
    short_req = 1;
    wait_drive(SHORT_L + 1, 0);
    step();
    checks++;
    if ({h_period_err, locked} !== 2'b10) begin errors++; $display("FAIL short_err: got herr%b locked%b want 1 0", h_period_err, locked); end
    step();
    checks++;
    if (h_period_err !== 1'b0) begin errors++; $display("FAIL short_err_width: got %b want 0", h_period_err); end
    wait_drive(0, 0);
    checks++;
    if (fd_n != fd0) begin errors++; $display("FAIL short_no_frame_done: got %0d want %0d", fd_n - fd0, 0); end
    checks++;
    if (frame_crc !== model_crc(0)) begin errors++; $display("FAIL short_crc_held: got %h want %h", frame_crc, model_crc(0)); end
    checks++;
    if (herr_n != h0 + 1 || verr_n != v0) begin errors++; $display("FAIL short_err_count: got h%0d v%0d want 1 0", herr_n - h0, verr_n - v0); end
    wait_drive(0, 0); step();
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL relock_early: got %b want 0", locked); end
    wait_drive(0, 0); step();
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL relock: got %b want 1", locked); end
  endtask

  task automatic test_blank;
    int h0, v0;
    h0 = herr_n; v0 = verr_n;
    checks++;
    if (blank_err !== 1'b0) begin errors++; $display("FAIL blank_pre: got %b want 0", blank_err); end
    inj_req = 1;
    wait_drive(INJ_L, INJ_C);
    checks++;
    if (blank_err !== 1'b0) begin errors++; $display("FAIL blank_early: got %b want 0", blank_err); end
    step();
    checks++;
    if (blank_err !== 1'b1) begin errors++; $display("FAIL blank_set: got %b want 1", blank_err); end
    wait_drive(0, 0);
    wait_drive(0, 0);
    wait_drive(0, 0);
    checks++;
    if ({blank_err, locked} !== 2'b11) begin errors++; $display("FAIL blank_sticky: got blank%b locked%b want 1 1", blank_err, locked); end
    checks++;
    if (herr_n != h0 || verr_n != v0) begin errors++; $display("FAIL blank_period_errs: got h%0d v%0d want 0", herr_n - h0, verr_n - v0); end
  endtask

  task automatic test_xor_crc;
    next_pat = 1;
    wait_drive(0, 0);
    wait_fd(fd_n + 1);
    checks++;
    if (frame_crc !== model_crc(1)) begin errors++; $display("FAIL crc_xor: got %h want %h", frame_crc, model_crc(1)); end
  endtask

  task automatic test_reset_midframe;
    int pv0;
    wait_drive(VS + 5, 20);
    reset = 1'b1;
    step();
    checks++;
    if ({pixel_valid, pixel_x, pixel_y, pixel_rgb, frame_done, frame_crc, locked,
         h_period_err, v_period_err, blank_err} !== 54'd0) begin
      errors++; $display("FAIL midframe_reset: got nonzero outputs, want all 0");
    end
    reset = 1'b0;
    pv0 = pv_total;
    wait_drive(0, 0);
    checks++;
    if (pv_total != pv0) begin errors++; $display("FAIL search_no_pixels: got %0d want 0", pv_total - pv0); end
    wait_drive(0, 0); step();
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL reset_relock_early: got %b want 0", locked); end
    wait_drive(0, 0); step();
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL reset_relock: got %b want 1", locked); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_nominal();
    test_corners();
    test_short_line();
    test_blank();
    test_xor_crc();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
Receive-side counterpart of the VGA timing/colour generator. Samples h_sync, v_sync and 12-bit rgb on the pixel clock and recovers the pixel grid, producing per-pixel coordinates and colour. Measures line and frame periods, locks to nominal 640x480@60 timing, flags timing and blanking violations, and computes a per-frame CRC. Used in simulation and on-board self-check to close the loop on the display path.

Parameters:
H_TOTAL, 800, expected clocks between successive hsync rising edges
V_TOTAL, 525, expected lines between successive vsync rising edges
H_VISIBLE, 640, visible pixels per line
V_VISIBLE, 480, visible lines per frame
H_START, 49, clocks from first high hsync pin sample to first visible pixel sample
V_START, 33, line-count value of the first visible line (see Behaviour)
LOCK_FRAMES, 2, consecutive clean frames required to assert locked

Ports:
clk  in  1  pixel clock (25 MHz)
reset  in  1  synchronous, active-high reset
h_sync  in  1  horizontal sync, active low
v_sync  in  1  vertical sync, active low
rgb  in  12  {R[3:0],G[3:0],B[3:0]}
pixel_valid  out  1  registered pixel strobe, visible region only
pixel_x  out  10  column 0..H_VISIBLE-1
pixel_y  out  10  row 0..V_VISIBLE-1
pixel_rgb  out  12  captured colour
frame_done  out  1  one-cycle pulse after last visible pixel
frame_crc  out  16  CRC of last completed frame, held until next frame_done
locked  out  1  timing lock
h_period_err  out  1  one-cycle pulse, bad line period
v_period_err  out  1  one-cycle pulse, bad frame period
blank_err  out  1  sticky, non-zero rgb outside visible window while locked

Behaviour:
- Single clock, synchronous active-high reset. Reset values: all outputs 0. frame_crc is 0x0000. Sync sample registers reset to 1 (idle), so no false edge fires after reset.
- Input stage: h_sync, v_sync and rgb are registered once (s1) and then again (s2). A rising edge is s1=1 and s2=0.
- Horizontal: hc is an 11-bit counter that saturates at 2047. It clears to 0 on an hsync rise and otherwise increments.
  - On each hsync rise after the first, compare the prior interval with H_TOTAL. Mismatch gives an h_period_err pulse.
  - Visible columns are hc in [H_START-1, H_START-1+H_VISIBLE), offset by the input register.
- Vertical: lc is a 10-bit line counter. It clears to 0 on a vsync rise and increments on each hsync rise.
  - On each vsync rise, compare the previous lc+1 with V_TOTAL. Mismatch gives a v_period_err pulse.
  - Visible rows are lc in [V_START, V_START+V_VISIBLE).
- FSM:
  - SEARCH: reset state; go to ALIGN on the first vsync rise.
  - ALIGN: count clean frames (no period error). At LOCK_FRAMES, go to LOCKED and set locked=1.
  - LOCKED: any period error clears locked and returns to ALIGN with the clean count reset to 0.
- Pixel outputs are emitted in ALIGN and LOCKED only. pixel_valid, pixel_x, pixel_y and pixel_rgb appear 2 clocks after the rgb pin sample that carried the pixel. pixel_x/pixel_y are 0 when pixel_valid=0.
- frame_done pulses in the cycle after the pixel_valid for (H_VISIBLE-1, V_VISIBLE-1). frame_crc updates in the same cycle as frame_done.
- CRC:
  - Algorithm: CRC-16-CCITT, poly 0x1021, init 0xFFFF, 12 bits per visible pixel, rgb[11] first, no reflection, no final XOR.
  - Reset to init on the first visible pixel of each frame.
  - A frame interrupted by a period error produces no frame_done, and frame_crc is unchanged.
- blank_err: set when locked=1 and rgb != 0 is sampled outside the visible window. Cleared only by reset.
- Simultaneous hsync and vsync rise: the vsync clear has priority (lc=0), and the line-period check still runs.
- Reset mid-frame: all state returns to reset values on the next edge, FSM returns to SEARCH, and any partial CRC is discarded.

Decomposition:
- Shared package vga_timing_pkg: H_/V_ visible, front, sync, back and total constants, state encoding, CRC polynomial and init value.
- Sub-module crc16_ccitt_12: combinational next-CRC for a 12-bit data word. Instantiated once.

Test Plan:
- Nominal timing, reset then frames of solid rgb=0xF00 with 0 in blanking:
  - locked rises at the vsync rise ending the 2nd clean frame.
  - Exactly 307200 pixel_valid per frame.
  - frame_done every 420000 clocks.
  - No errors.
- Pixel (0,0)=0x123 and pixel (639,479)=0x0AB:
  - pixel_valid with pixel_x=0, pixel_y=0, pixel_rgb=0x123 exactly 2 clocks after the pin sample.
  - Last pixel reports 639/479/0x0AB, followed by frame_done the next cycle.
- One line shortened to 799 clocks while locked:
  - Single h_period_err pulse, locked=0.
  - No frame_done for that frame, frame_crc unchanged.
  - locked returns after 2 further clean frames.
- rgb=0x001 for one clock at hc in h-blank while locked: blank_err=1 and remains set through later clean frames until reset.
- Frame of rgb = x XOR y (12-bit): frame_crc equals the bench model CRC-16-CCITT (0x1021, init 0xFFFF, 12-bit MSB-first).
- Reset asserted mid-frame at line 200: the next cycle has all outputs 0 and the FSM in SEARCH; relock requires a vsync rise plus 2 clean frames.
